// File: rtl/cpu_pkg.sv
// Shared CPU types: default datapath widths and the store-buffer entry layout.
package cpu_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    // One queued store at default width: target address and the data to write.
    typedef struct packed {
        logic [DEF_XLEN-1:0] addr;
        logic [DEF_XLEN-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/cpu_store_fifo.sv
// Generic circular FIFO with occupancy count. Pointers wrap modulo DEPTH
// (DEPTH is a power of two). Storage is not reset; only pointers and count are.
// The raw storage and write pointer are exported so a parent can search entries.
module cpu_store_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [DEPTH-1:0][WIDTH-1:0]  ents
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr;

    // Entry storage: written on push, never cleared.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign ents  = mem;

endmodule

// File: rtl/cpu_commit_sb.sv
// Commit stage with integrated store buffer. Registers committed results into
// writeback, exposes forwarding/hazard views combinationally, and drains queued
// stores to the data-memory port over valid/ready.
// Optional feature macro: CPU_COMMIT_SB_FWD_EN enables store-buffer address lookup.
module cpu_commit_sb
    import cpu_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_reg_write,
    input  logic                          in_mem_read,
    input  logic                          in_mem_write,
    input  logic [REG_AW-1:0]             in_reg_dest,
    input  logic [XLEN-1:0]               in_alu_result,
    input  logic [XLEN-1:0]               in_store_data,
    input  logic                          flush,
    output logic                          wb_valid,
    output logic                          wb_reg_write,
    output logic [REG_AW-1:0]             wb_reg_dest,
    output logic [XLEN-1:0]               wb_data,
    output logic [REG_AW-1:0]             fw_rd,
    output logic                          fw_write,
    output logic [XLEN-1:0]               fw_value,
    output logic                          hd_mem_read,
    output logic [REG_AW-1:0]             hd_rd,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [XLEN-1:0]               mem_req_addr,
    output logic [XLEN-1:0]               mem_req_data,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    input  logic [XLEN-1:0]               lu_addr,
    output logic                          lu_hit,
    output logic [XLEN-1:0]               lu_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH+1);
    localparam int EW = 2*XLEN;

    logic                           accept, push, pop, live;
    logic [EW-1:0]                  head;
    logic [PW-1:0]                  wr_ptr;
    logic [SB_DEPTH-1:0][EW-1:0]    ents;

    // in_ready depends only on occupancy, never on the presented instruction.
    assign in_ready = (sb_count != CW'(SB_DEPTH));
    assign live     = in_valid & ~flush;
    assign accept   = live & in_ready;
    assign push     = accept & in_mem_write;
    assign pop      = mem_req_valid & mem_req_ready;

    assign fw_rd       = in_reg_dest;
    assign fw_write    = in_reg_write & live;
    assign fw_value    = in_alu_result;
    assign hd_mem_read = in_mem_read & live;
    assign hd_rd       = in_reg_dest;

    // Writeback pipeline register; dest/data only move on an accepted instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_dest  <= '0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= accept;
            wb_reg_write <= accept & in_reg_write;
            if (accept) begin
                wb_reg_dest <= in_reg_dest;
                wb_data     <= in_alu_result;
            end
        end
    end

    cpu_store_fifo #(.DEPTH(SB_DEPTH), .WIDTH(EW)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .wdata  ({in_alu_result, in_store_data}),
        .pop    (pop),
        .rdata  (head),
        .count  (sb_count),
        .wr_ptr (wr_ptr),
        .ents   (ents)
    );

    // Head entry comes straight from storage, so it stays stable while stalled.
    assign mem_req_valid = (sb_count != '0);
    assign mem_req_addr  = head[EW-1:XLEN];
    assign mem_req_data  = head[XLEN-1:0];

`ifdef CPU_COMMIT_SB_FWD_EN
    logic [PW-1:0] idx;

    // Walk from oldest to youngest valid entry so the youngest match wins.
    always_comb begin
        lu_hit  = 1'b0;
        lu_data = '0;
        idx     = '0;
        for (int i = SB_DEPTH-1; i >= 0; i--) begin
            idx = wr_ptr - PW'(i+1);
            if ((CW'(i) < sb_count) && (ents[idx][EW-1:XLEN] == lu_addr)) begin
                lu_hit  = 1'b1;
                lu_data = ents[idx][XLEN-1:0];
            end
        end
    end
`else
    logic lu_unused;

    assign lu_hit    = 1'b0;
    assign lu_data   = '0;
    assign lu_unused = ^{lu_addr, ents, wr_ptr};
`endif

endmodule

// File: tb/tb_cpu_commit_sb.sv
// Scoreboard bench for cpu_commit_sb: the driver pushes expected writeback
// results and memory requests; a negedge monitor pops and compares them.
module tb_cpu_commit_sb;
    import cpu_pkg::*;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_reg_write, in_mem_read, in_mem_write;
    logic [4:0]  in_reg_dest;
    logic [31:0] in_alu_result, in_store_data;
    logic        flush;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_data;
    logic [4:0]  fw_rd, hd_rd;
    logic        fw_write, hd_mem_read;
    logic [31:0] fw_value;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [2:0]  sb_count;
    logic [31:0] lu_addr, lu_data;
    logic        lu_hit;

    int n_tests = 0;
    int n_fail  = 0;

    sb_entry_t sb_q[$];
    wb_exp_t   wb_q[$];

    cpu_commit_sb #(.XLEN(32), .REG_AW(5), .SB_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_dest(in_reg_dest), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .flush(flush),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
        .fw_rd(fw_rd), .fw_write(fw_write), .fw_value(fw_value),
        .hd_mem_read(hd_mem_read), .hd_rd(hd_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .sb_count(sb_count),
        .lu_addr(lu_addr), .lu_hit(lu_hit), .lu_data(lu_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every writeback and every memory handshake against the queues.
    always @(negedge clock) begin
        if (reset) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
                else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_reg_write", wb_reg_write, e.rw);
                    chk("wb_reg_dest", wb_reg_dest, e.rd);
                    chk("wb_data", wb_data, e.data);
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                if (sb_q.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    sb_entry_t s;
                    s = sb_q.pop_front();
                    chk("mem_addr", mem_req_addr, s.addr);
                    chk("mem_data", mem_req_data, s.data);
                end
            end
        end
    end

    // Present one instruction for one cycle; called and returns at posedge+1.
    task automatic issue(input logic w, input logic r, input logic m, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd, input logic fl,
                         input logic exp_acc);
        in_valid = 1'b1; in_reg_write = w; in_mem_read = r; in_mem_write = m;
        in_reg_dest = rd; in_alu_result = alu; in_store_data = sd; flush = fl;
        #1;
        if (!fl) chk("in_ready", in_ready, exp_acc);
        chk("fw_write", fw_write, w & ~fl);
        chk("hd_mem_read", hd_mem_read, r & ~fl);
        if (exp_acc && !fl) begin
            wb_q.push_back('{rw: w, rd: rd, data: alu});
            if (m) sb_q.push_back('{addr: alu, data: sd});
        end
        @(posedge clock); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        flush = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_count != 0; k++) begin
            @(posedge clock); #1;
        end
        chk("drain_done", sb_count, 0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
        in_mem_write = 1'b0; in_reg_dest = '0; in_alu_result = '0; in_store_data = '0;
        flush = 1'b0; mem_req_ready = 1'b0; lu_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_dest", wb_reg_dest, 0);
        chk("rst_count", sb_count, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_lu_hit", lu_hit, 0);
        @(posedge clock); #1;

        // ALU op rd=5 -> 0x1234, forwarding visible in the same cycle
        in_valid = 1'b1; in_reg_write = 1'b1; in_reg_dest = 5'd5; in_alu_result = 32'h1234;
        #1;
        chk("fw_value", fw_value, 32'h1234);
        chk("fw_rd", fw_rd, 5);
        issue(1, 0, 0, 5'd5, 32'h1234, 0, 0, 1);
        chk("wb_valid_alu", wb_valid, 1);
        chk("wb_data_alu", wb_data, 32'h1234);
        issue(1, 1, 0, 5'd7, 32'h80, 0, 0, 1);     // load
        chk("hd_rd_hold", wb_reg_dest, 7);
        idle();
        chk("wb_idle", wb_valid, 0);
        chk("wb_data_hold", wb_data, 32'h80);

        // Fill with ready low, then drain in order
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(0, 0, 1, 5'd0, 32'h100 + 32'(4*i), 32'hD0 + 32'(i), 0, 1);
        chk("full_count", sb_count, 4);
        chk("full_mem_valid", mem_req_valid, 1);
        issue(1, 0, 0, 5'd3, 32'h55, 0, 0, 0);
        chk("held_addr", mem_req_addr, 32'h100);
        issue(1, 0, 0, 5'd3, 32'h55, 0, 0, 0);
        chk("held_data", mem_req_data, 32'hD0);
        mem_req_ready = 1'b1;
        issue(1, 0, 0, 5'd3, 32'h55, 0, 0, 0);
        chk("pop1_count", sb_count, 3);
        issue(1, 0, 0, 5'd3, 32'h55, 0, 0, 1);
        chk("pop2_count", sb_count, 2);
        idle();
        chk("pop3_count", sb_count, 1);
        idle();
        chk("pop4_count", sb_count, 0);
        chk("empty_mem_valid", mem_req_valid, 0);

        // Full + ready + store: pop first, then push-and-pop each cycle across wrap
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(0, 0, 1, 5'd0, 32'h200 + 32'(4*i), 32'h20 + 32'(i), 0, 1);
        mem_req_ready = 1'b1;
        issue(0, 0, 1, 5'd0, 32'h300, 32'h30, 0, 0);
        chk("wrap_first_count", sb_count, 3);
        for (int i = 0; i < 10; i++)
            issue(0, 0, 1, 5'd0, 32'h300 + 32'(4*i), 32'h30 + 32'(i), 0, 1);
        chk("wrap_steady_count", sb_count, 3);
        idle();
        drain();

        // Flush kills only the presented store
        mem_req_ready = 1'b0;
        issue(0, 0, 1, 5'd0, 32'h500, 32'h1, 0, 1);
        issue(0, 0, 1, 5'd0, 32'h504, 32'h2, 0, 1);
        issue(1, 0, 1, 5'd9, 32'h508, 32'h3, 1, 0);
        chk("flush_wb_valid", wb_valid, 0);
        chk("flush_count", sb_count, 2);
        idle();
        mem_req_ready = 1'b1;
        drain();

        // Store-buffer lookup
        mem_req_ready = 1'b0;
        issue(0, 0, 1, 5'd0, 32'h40, 32'hA, 0, 1);
        issue(0, 0, 1, 5'd0, 32'h40, 32'hB, 0, 1);
        issue(0, 0, 1, 5'd0, 32'h50, 32'hC, 0, 1);
        idle();
        lu_addr = 32'h40; #1;
`ifdef CPU_COMMIT_SB_FWD_EN
        chk("lu_hit_40", lu_hit, 1);
        chk("lu_data_40", lu_data, 32'hB);
        lu_addr = 32'h44; #1;
        chk("lu_hit_44", lu_hit, 0);
        lu_addr = 32'h50; #1;
        chk("lu_data_50", lu_data, 32'hC);
`else
        chk("lu_hit_off", lu_hit, 0);
        chk("lu_data_off", lu_data, 0);
`endif
        lu_addr = '0;
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        drain();

        // Reset with 3 stores queued discards them
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(0, 0, 1, 5'd0, 32'h600 + 32'(4*i), 32'h60 + 32'(i), 0, 1);
        idle();
        chk("pre_rst_count", sb_count, 3);
        @(negedge clock); #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_count", sb_count, 0);
        chk("mid_rst_mem_valid", mem_req_valid, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        sb_q.delete();
        wb_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        mem_req_ready = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_count", sb_count, 0);

        chk("sb_q_empty", sb_q.size(), 0);
        chk("wb_q_empty", wb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_commit_sb.md
# cpu_commit_sb

Parametrised commit stage with an integrated store buffer. It registers committed results into the writeback stage and publishes forwarding and hazard information combinationally from its inputs. Committed stores are queued in a SB_DEPTH-entry FIFO and drained to the data-memory port through a valid/ready handshake. It sits between the commit and writeback pipeline stages.

## Interface
- XLEN, 32: data/address width
- REG_AW, 5: register-index width
- SB_DEPTH, 4: store-buffer entries; power of two, ≥2
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  commit slot holds an instruction
- in_ready  out  1  stage can accept; equals !sb_full
- in_reg_write  in  1  instruction writes rd
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_reg_dest  in  REG_AW  destination register
- in_alu_result  in  XLEN  ALU result; store address when in_mem_write
- in_store_data  in  XLEN  store data
- flush  in  1  kill the instruction presented this cycle
- wb_valid, wb_reg_write  out  1 each  registered to writeback
- wb_reg_dest  out  REG_AW; wb_data  out  XLEN
- fw_rd  out  REG_AW; fw_write  out  1; fw_value  out  XLEN  forwarding-unit view
- hd_mem_read  out  1; hd_rd  out  REG_AW  hazard-unit view
- mem_req_valid  out  1; mem_req_ready  in  1
- mem_req_addr, mem_req_data  out  XLEN each
- sb_count  out  $clog2(SB_DEPTH+1)  buffer occupancy
- lu_addr  in  XLEN; lu_hit  out  1; lu_data  out  XLEN  store-buffer lookup (see Configuration)

## Operation
- accept = in_valid & in_ready & !flush.
- fw_rd=in_reg_dest, fw_write=in_reg_write&in_valid&!flush, fw_value=in_alu_result; hd_mem_read=in_mem_read&in_valid&!flush, hd_rd=in_reg_dest. All combinational.
- Writeback registers: every cycle wb_valid<=accept; wb_reg_write<=accept&in_reg_write; wb_reg_dest, wb_data<=in_reg_dest, in_alu_result. When not accepted, dest/data hold their previous values.
- Store buffer: circular FIFO with wr_ptr, rd_ptr of log2(SB_DEPTH) bits wrapping modulo SB_DEPTH, plus count.
- push = accept & in_mem_write; writes {in_alu_result, in_store_data} at wr_ptr.
- pop = mem_req_valid & mem_req_ready; mem_req_valid = count!=0; addr/data come from the rd_ptr entry (registered storage, no input bypass).
- Same-cycle push and pop: count unchanged, both pointers advance. Legal when full because in_ready=0 blocks the push.
- in_ready = (count != SB_DEPTH). Deliberately conservative: non-store instructions also stall when full. Independent of in_mem_write, so no combinational path from in_* to in_ready.
- flush kills only the presented instruction. Entries already in the buffer are committed and always drain.
- mem_req_valid, once asserted, holds with stable addr/data until the handshake.

## Timing
- Commit → writeback latency: 1 cycle. Store accept → mem_req_valid: 1 cycle when the buffer was empty.
- Drain throughput: 1 entry/cycle with mem_req_ready held high.
- Reset (asynchronous assert, synchronous-release safe): wb_valid=0, wb_reg_write=0, wb_reg_dest=0, wb_data=0, pointers=0, count=0, mem_req_valid=0, in_ready=1, lu_hit=0. Storage contents are not reset.
- Reset mid-drain discards all buffered stores and drops mem_req_valid immediately.

## Configuration
- CPU_COMMIT_SB_FWD_EN defined: lu_hit=1 when any valid entry's address equals lu_addr. lu_data is the youngest matching entry's data, found by searching from wr_ptr-1 back to rd_ptr. Purely combinational.
- Undefined: lu_hit=0, lu_data=0, lu_addr ignored, no comparators synthesised.

## Structure
- Shared package cpu_pkg holds the sb_entry_t struct {addr, data} and default widths (XLEN, REG_AW).
- One sub-module, cpu_store_fifo: generic circular FIFO with count. The lookup logic lives in cpu_commit_sb.

## Test plan
- Reset low mid-operation with 3 entries queued → next sample: sb_count=0, mem_req_valid=0, wb_valid=0, in_ready=1.
- ALU op, rd=5, result 0x1234, accepted → fw_value=0x1234 in the same cycle; one cycle later wb_valid=1, wb_reg_dest=5, wb_data=0x1234.
- 4 stores with mem_req_ready=0 (SB_DEPTH=4) → sb_count=4, in_ready=0, a following ALU op is held; ready=1 → drains in order, one entry per cycle, in_ready=1 after the first pop.
- Full buffer with ready=1 and in_valid store → pop only on the first cycle, then push; pointer wrap verified over 10 stores in push order.
- flush=1 with a store presented → no push, wb_valid=0 next cycle, existing entries still drain.
- FWD_EN: stores to 0x40 (data 0xA), then 0x40 (data 0xB) → lu_addr=0x40 gives lu_hit=1, lu_data=0xB; lu_addr=0x44 gives lu_hit=0.
